etpu_gpio_tx: RTL and testbench
===============================

ETPU_GPIO_TX -- requirements
Module: etpu_gpio_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result-FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, meaning cycles each word is presented with out_en high (minimum 1).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  result word offered by the array.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept; equals not-full.
REQ-007 SHALL have port in_data  input  16  result word.
REQ-008 SHALL have port in_last  input  1  final word of the current burst.
REQ-009 SHALL have port out_data  output  16  word driven to the result pins.
REQ-010 SHALL have port out_tag  output  4  word index within the burst, driven to the load_end pins.
REQ-011 SHALL have port out_en  output  1  data-valid strobe to the en pin.
REQ-012 SHALL have port dbg_active  output  1  high while a burst is in progress.

Function
REQ-013 SHALL push {in_data,in_last} into the FIFO on each edge with in_valid and in_ready both high; no push when full.
REQ-014 SHALL implement FSM states IDLE, HOLD, GAP, and CSUM (CSUM only with the macro).
REQ-015 SHALL, in IDLE with FIFO non-empty, pop one entry, register it to out_data, set out_tag to the tag counter, set out_en=1 and dbg_active=1, and enter HOLD.
REQ-016 SHALL keep out_en=1 for exactly HOLD_CYCLES cycles per word, then enter GAP with out_en=0 for at least one cycle; out_data and out_tag stay stable through HOLD and GAP.
REQ-017 SHALL, in GAP after a non-last word, pop the next entry and re-enter HOLD with out_tag+1 if the FIFO is non-empty, otherwise remain in GAP (underrun) with dbg_active=1.
REQ-018 SHALL, in GAP after a last word, clear the tag counter, drop dbg_active, and return to IDLE (or go to CSUM with the macro).
REQ-019 SHALL wrap the tag counter 15->0 within long bursts (14->0 with the macro, since 4'hF is reserved).
REQ-020 SHALL give a latency of 2 edges from acceptance into an empty FIFO in IDLE to out_en high.
REQ-021 SHALL allow a push and a pop on the same edge; occupancy is then unchanged.
REQ-022 SHALL drive all outputs from registers (in_ready may derive combinationally from registered occupancy).

Reset
REQ-023 SHALL, on rstb low at any time including mid-burst, immediately flush the FIFO, clear the tag counter and checksum, force state IDLE, and drive out_data=0, out_tag=0, out_en=0, dbg_active=0, in_ready=0.
REQ-024 SHALL assert in_ready=1 on the first edge after rstb deasserts.

Configuration
REQ-025 SHALL, with macro ETPU_TX_CHECKSUM_EN defined, accumulate a 16-bit modulo-2^16 sum of all data words in the burst and, after the last word's GAP, present it in CSUM with out_tag=4'hF for HOLD_CYCLES cycles, followed by one GAP cycle, before dropping dbg_active.
REQ-026 SHALL, without ETPU_TX_CHECKSUM_EN, contain no checksum logic or CSUM state; tags wrap at 15.

Verification
REQ-027 SHALL verify a single burst: push 16'h1234 (in_last=1), HOLD_CYCLES=2 -> out_en high 2 cycles with out_data=16'h1234, out_tag=0, then dbg_active falls after the GAP cycle.
REQ-028 SHALL verify a 4-word burst 1,2,3,4 -> tags 0,1,2,3 in order with one out_en-low cycle between words; with the macro, a fifth word 16'h000A with tag F follows.
REQ-029 SHALL verify back-pressure: push 6 words with no pop progress, DEPTH=4 -> in_ready low after the 4th push; no word lost or duplicated.
REQ-030 SHALL verify underrun: stall in_valid for 10 cycles mid-burst -> out_en low, dbg_active high, and the tag continues at +1 on resume.
REQ-031 SHALL verify tag wrap: a 17-word burst -> tags 0..15,0 without the macro, and 0..14,0,1 with it.
REQ-032 SHALL verify reset mid-HOLD: pulse rstb low -> all outputs 0 asynchronously and the next burst starts at tag 0.

Source files
------------

// File: rtl/etpu_gpio_tx.sv
// Result-word transmitter: buffers array results and strobes them onto the GPIO pins.
// Latency: 2 edges from acceptance into an empty FIFO (in IDLE) to out_en high.
// Backpressure: in_ready drops when the result FIFO is full; out_en paces words at HOLD_CYCLES high + >=1 low.
//
// Ports:
//   clk, rstb               single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       result word handshake; in_data (16b), in_last marks the burst's final word
//   out_data, out_tag       word and its in-burst index driven to the result / load_end pins
//   out_en                  data-valid strobe for the en pin
//   dbg_active              high while a burst is in progress
// Optional feature: define ETPU_TX_CHECKSUM_EN to append a 16-bit burst checksum word
// (tag 4'hF) after every burst; tags then wrap 14->0 because 4'hF is reserved for it.
module etpu_gpio_tx #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic [15:0] out_data,
    output logic [3:0]  out_tag,
    output logic        out_en,
    output logic        dbg_active
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef ETPU_TX_CHECKSUM_EN
    localparam logic [3:0]      TAG_MAX   = 4'd14;
`else
    localparam logic [3:0]      TAG_MAX   = 4'd15;
`endif

`ifdef ETPU_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HOLD, GAP, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

    state_t          state;
    state_t          state_nxt;

    // Result FIFO: entry = {data, last}
    logic [16:0]     mem [DEPTH];
    logic [16:0]     rd_word;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            init_q;
    logic            push;
    logic            pop;

    logic [HW-1:0]   hold_cnt;
    logic [3:0]      tag_q;
    logic [3:0]      tag_inc;
    logic            last_q;
    logic            holding;
    logic            burst_end;
    logic            out_en_d;
    logic            dbg_active_d;

`ifdef ETPU_TX_CHECKSUM_EN
    logic [15:0]     csum_q;
    logic            csum_sent_q;
    logic            csum_start;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    // init_q keeps in_ready low until the first edge after reset release
    assign in_ready   = init_q & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign rd_word    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, in_last};
        end
    end

    // State register plus registered FSM outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            out_en     <= 1'b0;
            dbg_active <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_en     <= out_en_d;
            dbg_active <= dbg_active_d;
            init_q     <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = GAP;
            end
            GAP: begin
                if (last_q) begin
`ifdef ETPU_TX_CHECKSUM_EN
                    state_nxt = csum_sent_q ? IDLE : CSUM;
`else
                    state_nxt = IDLE;
`endif
                end else if (!fifo_empty) begin
                    state_nxt = HOLD;
                end
            end
`ifdef ETPU_TX_CHECKSUM_EN
            CSUM: begin
                if (hold_cnt == HOLD_LAST) state_nxt = GAP;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode; outputs are registered from these next values
    always_comb begin
        pop          = (state_nxt == HOLD) && (state != HOLD);
        out_en_d     = (state_nxt == HOLD);
        dbg_active_d = (state_nxt != IDLE);
        holding      = (state == HOLD);
        burst_end    = (state == GAP) && (state_nxt == IDLE);
        tag_inc      = (tag_q == TAG_MAX) ? 4'd0 : tag_q + 4'd1;
`ifdef ETPU_TX_CHECKSUM_EN
        csum_start   = (state == GAP) && (state_nxt == CSUM);
        if (state_nxt == CSUM) out_en_d = 1'b1;
        if (state == CSUM) holding = 1'b1;
`endif
    end

    // FIFO pointers, hold timer, tag counter and output data registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= '0;
            tag_q    <= '0;
            last_q   <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            // Restart the timer on every state change so each HOLD/CSUM gets a full window
            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (holding) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (pop) begin
                out_data <= rd_word[16:1];
                last_q   <= rd_word[0];
                if (state == IDLE) begin
                    out_tag <= tag_q;
                end else begin
                    tag_q   <= tag_inc;
                    out_tag <= tag_inc;
                end
            end
`ifdef ETPU_TX_CHECKSUM_EN
            if (csum_start) begin
                out_data <= csum_q;
                out_tag  <= 4'hF;
            end
`endif
            if (burst_end) tag_q <= '0;
        end
    end

`ifdef ETPU_TX_CHECKSUM_EN
    // Running modulo-2^16 sum of the words popped in the current burst
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
        end else begin
            if (pop) begin
                csum_q <= (state == IDLE) ? rd_word[16:1] : csum_q + rd_word[16:1];
            end
            if (csum_start) csum_sent_q <= 1'b1;
            if (burst_end) begin
                csum_q      <= '0;
                csum_sent_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_etpu_gpio_tx.sv
`timescale 1ns/1ps
module tb_etpu_gpio_tx;
    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 2;
`ifdef ETPU_TX_CHECKSUM_EN
    localparam int TAG_MOD     = 15;
    localparam int CSUM_EXTRA  = HOLD_CYCLES + 1;
`else
    localparam int TAG_MOD     = 16;
    localparam int CSUM_EXTRA  = 0;
`endif

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_en;
    logic        dbg_active;

    etpu_gpio_tx #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_en     (out_en),
        .dbg_active (dbg_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        is_csum;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state, written by the stimulus side only
    int          burst_idx = 0;
    logic [15:0] burst_sum = 16'h0;
    int          n_acc = 0;
    int          stall_cnt = 0;

    // Monitor state, written by the monitor only
    int          n_pop = 0;
    int          bursts_done = 0;
    int          dbg_len_last = 0;
    logic        mon_prev_en = 1'b0;
    logic        mon_prev_dbg = 1'b0;
    int          mon_run = 0;
    int          mon_dlen = 0;
    exp_t        mon_cur;
    logic        ready_up;

    // in_ready may only come up on the first edge after reset release
    always @(posedge clk or negedge rstb) begin
        if (!rstb) ready_up <= 1'b0;
        else       ready_up <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word, wait for acceptance, and record its expected presentation
    task automatic push_word(input logic [15:0] d, input logic l);
        int   t = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 300) begin
            stall_cnt++;
            cyc(1);
            t++;
        end
        check("push_accept", 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        cyc(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_acc++;
        e.data    = d;
        e.tag     = 4'(burst_idx % TAG_MOD);
        e.is_csum = 1'b0;
        exp_q.push_back(e);
        burst_sum = burst_sum + d;
        if (l) begin
`ifdef ETPU_TX_CHECKSUM_EN
            e.data    = burst_sum;
            e.tag     = 4'hF;
            e.is_csum = 1'b1;
            exp_q.push_back(e);
`endif
            burst_idx = 0;
            burst_sum = 16'h0;
        end else begin
            burst_idx++;
        end
    endtask

    task automatic wait_bursts(input int target);
        int t = 0;
        while (bursts_done < target && t < 2000) begin
            cyc(1);
            t++;
        end
        check("burst_complete", 32'(bursts_done >= target), 32'd1);
        check("no_words_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                mon_prev_en  = 1'b0;
                mon_prev_dbg = 1'b0;
                mon_run      = 0;
                mon_dlen     = 0;
                n_pop        = 0;
            end else begin
                if (out_en && !mon_prev_en) begin
                    check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_cur = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(mon_cur.data));
                        check("out_tag", 32'(out_tag), 32'(mon_cur.tag));
                        if (!mon_cur.is_csum) n_pop++;
                    end
                    mon_cur.data = out_data;
                    mon_cur.tag  = out_tag;
                    mon_run = 1;
                end else if (out_en) begin
                    mon_run++;
                    check("hold_stable", 32'({out_tag, out_data}), 32'({mon_cur.tag, mon_cur.data}));
                end else if (mon_prev_en) begin
                    check("hold_len", 32'(mon_run), 32'(HOLD_CYCLES));
                    check("gap_stable", 32'({out_tag, out_data}), 32'({mon_cur.tag, mon_cur.data}));
                end
                if (out_en) check("en_implies_active", 32'(dbg_active), 32'd1);
                check("in_ready", 32'(in_ready), 32'(ready_up && ((n_acc - n_pop) < DEPTH)));

                if (dbg_active) begin
                    mon_dlen++;
                end else if (mon_prev_dbg) begin
                    dbg_len_last = mon_dlen;
                    mon_dlen     = 0;
                    bursts_done++;
                end
                mon_prev_en  = out_en;
                mon_prev_dbg = dbg_active;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb = 0;
        int t;
        int len;

        // Reset state
        cyc(3);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_dbg_active", 32'(dbg_active), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rstb = 1'b1;
        check("release_in_ready_before_edge", 32'(in_ready), 32'd0);
        cyc(1);
        check("release_in_ready_after_edge", 32'(in_ready), 32'd1);
        cyc(2);

        // Single-word burst: latency and burst length
        push_word(16'h1234, 1'b1);
        check("latency_edge1_en", 32'(out_en), 32'd0);
        cyc(1);
        check("latency_edge2_en", 32'(out_en), 32'd1);
        check("single_data", 32'(out_data), 32'h1234);
        check("single_tag", 32'(out_tag), 32'd0);
        nb++;
        wait_bursts(nb);
        check("single_dbg_len", 32'(dbg_len_last), 32'(HOLD_CYCLES + 1 + CSUM_EXTRA));
        cyc(2);

        // Four-word burst 1,2,3,4
        for (int i = 1; i <= 4; i++) push_word(16'(i), i == 4);
        nb++;
        wait_bursts(nb);
        check("burst4_dbg_len", 32'(dbg_len_last), 32'(4 * (HOLD_CYCLES + 1) + CSUM_EXTRA));
        cyc(2);

        // Back-pressure: offer words faster than they drain
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) push_word(16'($urandom), i == 7);
        check("bp_stall_seen", 32'(stall_cnt > 0), 32'd1);
        nb++;
        wait_bursts(nb);
        check("bp_dbg_len", 32'(dbg_len_last), 32'(8 * (HOLD_CYCLES + 1) + CSUM_EXTRA));
        cyc(2);

        // Underrun mid-burst
        for (int i = 0; i < 3; i++) push_word(16'($urandom), 1'b0);
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            cyc(1);
            t++;
        end
        check("underrun_drained", 32'(exp_q.size()), 32'd0);
        cyc(HOLD_CYCLES + 2);
        for (int i = 0; i < 10; i++) begin
            check("underrun_en_low", 32'(out_en), 32'd0);
            check("underrun_dbg_high", 32'(dbg_active), 32'd1);
            cyc(1);
        end
        for (int i = 0; i < 2; i++) push_word(16'($urandom), i == 1);
        nb++;
        wait_bursts(nb);
        cyc(2);

        // Tag wrap over a 17-word burst
        for (int i = 0; i < 17; i++) push_word(16'($urandom), i == 16);
        nb++;
        wait_bursts(nb);
        check("wrap_dbg_len", 32'(dbg_len_last), 32'(17 * (HOLD_CYCLES + 1) + CSUM_EXTRA));
        cyc(2);

        // Randomized bursts with random inter-word idle time
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                push_word(16'($urandom), i == len - 1);
                cyc($urandom_range(0, 4));
            end
            nb++;
            wait_bursts(nb);
            cyc($urandom_range(0, 3));
        end

        // Reset in the middle of a HOLD
        for (int i = 0; i < 3; i++) push_word(16'($urandom), i == 2);
        t = 0;
        while (!out_en && t < 50) begin
            cyc(1);
            t++;
        end
        check("mid_hold_reached", 32'(out_en), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        check("async_rst_out_data", 32'(out_data), 32'd0);
        check("async_rst_out_tag", 32'(out_tag), 32'd0);
        check("async_rst_out_en", 32'(out_en), 32'd0);
        check("async_rst_dbg_active", 32'(dbg_active), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        n_acc     = 0;
        burst_idx = 0;
        burst_sum = 16'h0;
        @(posedge clk);
        cyc(2);
        rstb = 1'b1;
        check("rerelease_in_ready_before_edge", 32'(in_ready), 32'd0);
        cyc(1);
        check("rerelease_in_ready_after_edge", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2; i++) push_word(16'($urandom), i == 1);
        nb++;
        wait_bursts(nb);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
